commit_h1_hash: RTL and testbench
=================================

# commit_h1_hash

Downstream neighbour of `commit`. Once all 2^D_HYPERCUBE party commitments sit in the commit RAM, this block computes the first Fiat-Shamir challenge digest h1 = Hash(0x00000001 || salt || com[0] || … || com[N-1]). It masters the commit RAM read port, serves the message to `hash_mem_interface` on demand, and stores the 2·LAMBDA-bit digest in an internal RAM that the challenge-expansion stage reads.

## Interface
- PARAMETER_SET, "L1": selects LAMBDA = 128/192/256 for L1/L3/L5.
- D_HYPERCUBE, 8: N = 2^D_HYPERCUBE commitments.
- SALT_SIZE, 2·LAMBDA: salt bits; SALT_WORDS = SALT_SIZE/32.
- COMMIT_WORDS, LAMBDA·2^D_HYPERCUBE/32: 1024 for L1.
- MSG_WORDS, 1 + SALT_WORDS + COMMIT_WORDS: 1033 for L1.
- H1_SIZE, 2·LAMBDA: digest bits; H1_WORDS = H1_SIZE/32.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-low reset: low at a rising edge resets.
- i_start  in  1  one-cycle start pulse.
- i_salt, i_salt_addr, i_salt_wr_en  in  32 / clog2(SALT_WORDS) / 1  salt write port.
- o_commit_rd, o_commit_addr  out  1 / clog2(COMMIT_WORDS)  commit RAM read request.
- i_commit  in  32  commit RAM data, valid one cycle after the request.
- i_h1_rd, i_h1_addr  in  1 / clog2(H1_WORDS)  digest read port.
- o_h1  out  32  digest word, one cycle after read.
- o_done  out  1  one-cycle completion pulse.
- Hash port: o_hash_data_in (out 32), i_hash_addr (in clog2(MSG_WORDS)), i_hash_rd_en (in 1), i_hash_data_out (in 32), i_hash_data_out_valid (in 1), o_hash_data_out_ready (out 1), o_hash_input_length (out 32, bits), o_hash_output_length (out 32, bits), o_hash_start (out 1), o_hash_force_done (out 1), i_hash_force_done_ack (in 1).

## Operation
- FSM states: IDLE, START, RUN, FORCE, DONE.
- IDLE: the salt port writes the internal salt RAM. On i_start, go to START. Salt writes in any other state are dropped.
- START: assert o_hash_start for 1 cycle, then go to RUN.
- RUN: serve reads and collect output.
  - Message address map for i_hash_addr = a: a = 0 gives constant 0x00000001. 1 ≤ a ≤ SALT_WORDS gives salt[a-1]. Otherwise the word is commit[a-1-SALT_WORDS].
  - o_commit_rd = i_hash_rd_en when a is in the commit range. o_commit_addr is driven combinationally from a.
  - A registered source select muxes o_hash_data_in one cycle after i_hash_rd_en.
  - o_hash_data_out_ready = 1 in RUN only.
  - Each valid word is written to h1 RAM[cnt], then cnt increments.
  - When word H1_WORDS-1 is captured, go to FORCE.
- FORCE: hold o_hash_force_done = 1 until i_hash_force_done_ack = 1, then go to DONE.
- DONE: o_done = 1 for one cycle, then go to IDLE.
- o_hash_input_length = 32·MSG_WORDS, i.e. 33056 for L1. o_hash_output_length = H1_SIZE. Both are constants.
- i_start outside IDLE is ignored.
- The h1 read port is always live. Contents are stable from o_done until the next run.
- Digest words are stored in arrival order. Byte order is untouched.
- The block does not arbitrate the commit RAM. The integrator guarantees `commit` is idle when i_start is given.

## Timing
- Reset values: all outputs 0, FSM in IDLE, cnt = 0. Salt RAM and h1 RAM are not cleared.
- Reset mid-run: FSM returns to IDLE on the next edge and o_hash_force_done drops. The hash core is reset by the same reset.
- Read latency is 1 cycle for: hash message data, commit RAM data, salt RAM data, h1 digest.
- i_hash_data_out_valid outside RUN is not accepted: ready stays 0.
- Valid and capture of the last word in the same cycle: the FSM leaves RUN on that edge, so ready = 0 on the next cycle.
- o_done rises exactly 1 cycle after the ack is sampled.
- Start-to-done time is dominated by the hash core; the block adds 3 cycles (START, FORCE ack, DONE).

## Structure
- A shared sign package holds LAMBDA, SALT_WORDS, COMMIT_WORDS, MSG_WORDS and H1_WORDS per PARAMETER_SET.
- `commit` reuses the same package.
- Sub-module `mem_single` is instantiated twice: salt RAM (SALT_WORDS) and h1 RAM (H1_WORDS).
- The FSM, address decode and counter are inline.

## Test plan
- **Address map:** L1, salt = 0x0..0x7, commit model word k = k. Hash model reads addresses 0, 1, 9, 1032. Expect 0x00000001, 0x0, 0x0, 0x3FF, and o_commit_addr = 0 and 1023 on the commit reads.
- **Full run:** a behavioural hash returns words 0xA0..0xA7. Expect o_done once, then h1 reads 0..7 give 0xA0..0xA7, and o_hash_input_length = 33056.
- **Force-done handshake:** ack is delayed 5 cycles. o_hash_force_done stays high for 5 cycles, and o_done rises 1 cycle after ack.
- **Ignored inputs:** i_start pulsed during RUN, and a salt write during RUN. Expect no restart, salt RAM unchanged, and still exactly one o_done.
- **Reset mid-run:** i_rst low during RUN. Next cycle: IDLE, all outputs 0. A restart completes with correct h1.
- **Gaps in output:** valid de-asserted between digest words. Expect no duplicate or lost captures and cnt = 8 at FORCE.

Source files
------------

// File: rtl/commit_h1_hash_pkg.sv
// ----------------------------------------------------------------------------
// commit_h1_hash_pkg
// Shared sizing package for the sign pipeline (used by commit and
// commit_h1_hash). Derives LAMBDA and the word counts of the salt, the commit
// array, the h1 message and the h1 digest from the parameter set name, and
// holds the commit_h1_hash FSM and message-source encodings.
// ----------------------------------------------------------------------------
package commit_h1_hash_pkg;

    localparam int          DATA_W     = 32;
    // Leading domain-separation word of the h1 message.
    localparam logic [31:0] DOMAIN_TAG = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_FORCE,
        ST_DONE
    } state_e;

    // Which source feeds the hash message word on the cycle after a read.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CONST,
        SRC_SALT,
        SRC_COMMIT
    } src_e;

    // Parameter set names are two-character strings ("L1", "L3", "L5").
    function automatic int lambda_of(input logic [15:0] ps);
        if (ps == "L5") begin
            return 256;
        end else if (ps == "L3") begin
            return 192;
        end
        return 128;
    endfunction

    function automatic int salt_words(input logic [15:0] ps);
        return 2 * lambda_of(ps) / 32;
    endfunction

    function automatic int commit_words(input logic [15:0] ps, input int d);
        return lambda_of(ps) * (1 << d) / 32;
    endfunction

    function automatic int msg_words(input logic [15:0] ps, input int d);
        return 1 + salt_words(ps) + commit_words(ps, d);
    endfunction

    function automatic int h1_words(input logic [15:0] ps);
        return 2 * lambda_of(ps) / 32;
    endfunction

    // Address width that never collapses to zero bits.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/commit_h1_hash_mem_single.sv
// ----------------------------------------------------------------------------
// commit_h1_hash_mem_single
// Single-port RAM with one registered read port, used for the salt store and
// the h1 digest store. A write takes priority on the shared address; the read
// data register is cleared by reset so the block's outputs come up at zero,
// while the array contents themselves are never cleared.
//
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset (read register only)
//   we_i     write enable
//   re_i     read enable; rdata_o updates on the next edge
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  registered read data
// ----------------------------------------------------------------------------
module commit_h1_hash_mem_single
    import commit_h1_hash_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/commit_h1_hash.sv
// ----------------------------------------------------------------------------
// commit_h1_hash
// Computes h1 = Hash(0x00000001 || salt || com[0] || ... || com[N-1]).
// Serves the message to the hash core on demand (reading the salt from an
// internal RAM and the commitments from the external commit RAM), stores the
// returned digest words in arrival order in an internal RAM, then closes the
// hash core with a force-done handshake and pulses o_done.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-low reset
//   i_start                      start pulse (honoured in IDLE only)
//   i_salt, i_salt_addr,
//   i_salt_wr_en                 salt write port (honoured in IDLE only)
//   o_commit_rd, o_commit_addr   commit RAM read request
//   i_commit                     commit RAM data, one cycle after request
//   i_h1_rd, i_h1_addr, o_h1     digest read port, one cycle latency
//   o_done                       one-cycle completion pulse
//   o_hash_* / i_hash_*          hash core message / digest / control port
// ----------------------------------------------------------------------------
module commit_h1_hash
    import commit_h1_hash_pkg::*;
#(
    parameter  logic [15:0] PARAMETER_SET = "L1",
    parameter  int          D_HYPERCUBE   = 8,
    parameter  int          SALT_SIZE     = 2 * lambda_of(PARAMETER_SET),
    parameter  int          COMMIT_WORDS  = commit_words(PARAMETER_SET, D_HYPERCUBE),
    parameter  int          H1_SIZE       = 2 * lambda_of(PARAMETER_SET),
    localparam int          SALT_WORDS    = SALT_SIZE / 32,
    localparam int          MSG_WORDS     = 1 + SALT_WORDS + COMMIT_WORDS,
    localparam int          H1_WORDS      = H1_SIZE / 32,
    localparam int          SALT_AW       = addr_w(SALT_WORDS),
    localparam int          COMMIT_AW     = addr_w(COMMIT_WORDS),
    localparam int          MSG_AW        = addr_w(MSG_WORDS),
    localparam int          H1_AW         = addr_w(H1_WORDS),
    localparam int          CNT_W         = $clog2(H1_WORDS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,

    input  logic [31:0]          i_salt,
    input  logic [SALT_AW-1:0]   i_salt_addr,
    input  logic                 i_salt_wr_en,

    output logic                 o_commit_rd,
    output logic [COMMIT_AW-1:0] o_commit_addr,
    input  logic [31:0]          i_commit,

    input  logic                 i_h1_rd,
    input  logic [H1_AW-1:0]     i_h1_addr,
    output logic [31:0]          o_h1,

    output logic                 o_done,

    output logic [31:0]          o_hash_data_in,
    input  logic [MSG_AW-1:0]    i_hash_addr,
    input  logic                 i_hash_rd_en,
    input  logic [31:0]          i_hash_data_out,
    input  logic                 i_hash_data_out_valid,
    output logic                 o_hash_data_out_ready,
    output logic [31:0]          o_hash_input_length,
    output logic [31:0]          o_hash_output_length,
    output logic                 o_hash_start,
    output logic                 o_hash_force_done,
    input  logic                 i_hash_force_done_ack
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    src_e             src_q, src_d;

    logic             in_run;
    logic             msg_rd;
    logic             addr_is_const;
    logic             addr_is_salt;
    logic             addr_is_commit;
    logic             capture;
    logic             last_word;

    logic             salt_we;
    logic             salt_re;
    logic [SALT_AW-1:0] salt_addr;
    logic [31:0]      salt_rdata;

    logic             h1_re;
    logic [H1_AW-1:0] h1_addr;

    // ------------------------------------------------------------------
    // Message address decode
    // ------------------------------------------------------------------
    assign in_run         = (state_q == ST_RUN);
    assign msg_rd         = in_run && i_hash_rd_en;
    assign addr_is_const  = (i_hash_addr == '0);
    assign addr_is_salt   = !addr_is_const && (i_hash_addr <= MSG_AW'(SALT_WORDS));
    assign addr_is_commit = (i_hash_addr > MSG_AW'(SALT_WORDS));

    assign o_commit_rd   = msg_rd && addr_is_commit;
    assign o_commit_addr = addr_is_commit
                         ? COMMIT_AW'(i_hash_addr - MSG_AW'(SALT_WORDS + 1))
                         : '0;

    // ------------------------------------------------------------------
    // Salt RAM: written from the salt port while idle, read by the hash core.
    // ------------------------------------------------------------------
    assign salt_we   = (state_q == ST_IDLE) && i_salt_wr_en;
    assign salt_re   = msg_rd && addr_is_salt;
    assign salt_addr = salt_we ? i_salt_addr : SALT_AW'(i_hash_addr - MSG_AW'(1));

    commit_h1_hash_mem_single #(
        .DEPTH (SALT_WORDS),
        .WIDTH (DATA_W)
    ) u_salt_ram (
        .clk_i   (i_clk),
        .rst_ni  (i_rst),
        .we_i    (salt_we),
        .re_i    (salt_re),
        .addr_i  (salt_addr),
        .wdata_i (i_salt),
        .rdata_o (salt_rdata)
    );

    // ------------------------------------------------------------------
    // h1 RAM: digest capture owns the address while a word arrives, the
    // external read port has it otherwise.
    // ------------------------------------------------------------------
    assign capture   = in_run && i_hash_data_out_valid;
    assign last_word = (cnt_q == CNT_W'(H1_WORDS - 1));
    assign h1_re     = i_h1_rd && !capture;
    assign h1_addr   = capture ? cnt_q[H1_AW-1:0] : i_h1_addr;

    commit_h1_hash_mem_single #(
        .DEPTH (H1_WORDS),
        .WIDTH (DATA_W)
    ) u_h1_ram (
        .clk_i   (i_clk),
        .rst_ni  (i_rst),
        .we_i    (capture),
        .re_i    (h1_re),
        .addr_i  (h1_addr),
        .wdata_i (i_hash_data_out),
        .rdata_o (o_h1)
    );

    // ------------------------------------------------------------------
    // Message data: the source is chosen by a register loaded on the read,
    // so the mux lines up with the one-cycle latency of both RAMs.
    // ------------------------------------------------------------------
    always_comb begin
        src_d = src_q;
        if (msg_rd) begin
            if (addr_is_const) begin
                src_d = SRC_CONST;
            end else if (addr_is_salt) begin
                src_d = SRC_SALT;
            end else begin
                src_d = SRC_COMMIT;
            end
        end
    end

    always_comb begin
        case (src_q)
            SRC_CONST:  o_hash_data_in = DOMAIN_TAG;
            SRC_SALT:   o_hash_data_in = salt_rdata;
            SRC_COMMIT: o_hash_data_in = i_commit;
            default:    o_hash_data_in = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and digest counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (capture) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                if (i_hash_force_done_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= SRC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    assign o_hash_start          = (state_q == ST_START);
    assign o_hash_data_out_ready = in_run;
    assign o_hash_force_done     = (state_q == ST_FORCE);
    assign o_done                = (state_q == ST_DONE);

    assign o_hash_input_length   = 32'(32 * MSG_WORDS);
    assign o_hash_output_length  = 32'(H1_SIZE);

endmodule

// File: tb/tb_commit_h1_hash.sv
module tb_commit_h1_hash;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] salt_d;
    logic [2:0]  salt_a;
    logic        salt_we;
    logic        commit_rd;
    logic [9:0]  commit_addr;
    logic [31:0] commit_data;
    logic        h1_rd;
    logic [2:0]  h1_addr;
    logic [31:0] h1;
    logic        done;
    logic [31:0] hash_din;
    logic [10:0] hash_addr;
    logic        hash_rd;
    logic [31:0] hash_dout;
    logic        hash_valid;
    logic        ready;
    logic [31:0] in_len;
    logic [31:0] out_len;
    logic        hash_start;
    logic        force_done;
    logic        ack;

    always #5 clk = ~clk;

    commit_h1_hash dut (
        .i_clk                 (clk),
        .i_rst                 (rst_n),
        .i_start               (start),
        .i_salt                (salt_d),
        .i_salt_addr           (salt_a),
        .i_salt_wr_en          (salt_we),
        .o_commit_rd           (commit_rd),
        .o_commit_addr         (commit_addr),
        .i_commit              (commit_data),
        .i_h1_rd               (h1_rd),
        .i_h1_addr             (h1_addr),
        .o_h1                  (h1),
        .o_done                (done),
        .o_hash_data_in        (hash_din),
        .i_hash_addr           (hash_addr),
        .i_hash_rd_en          (hash_rd),
        .i_hash_data_out       (hash_dout),
        .i_hash_data_out_valid (hash_valid),
        .o_hash_data_out_ready (ready),
        .o_hash_input_length   (in_len),
        .o_hash_output_length  (out_len),
        .o_hash_start          (hash_start),
        .o_hash_force_done     (force_done),
        .i_hash_force_done_ack (ack)
    );

    // Behavioural environment: commit RAM with one-cycle read latency.
    logic [31:0] commit_mem [1024];
    always @(posedge clk) begin
        if (commit_rd) commit_data <= commit_mem[commit_addr];
    end

    // Event counters sampled mid-cycle.
    int done_seen  = 0;
    int force_seen = 0;
    always @(negedge clk) begin
        if (done)       done_seen  <= done_seen + 1;
        if (force_done) force_seen <= force_seen + 1;
    end

    // Reference state.
    logic [31:0] salt_ref   [8];
    logic [31:0] digest_ref [8];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        crd;
        logic [9:0]  caddr;
    } amap_t;
    amap_t amap [6];

    // Message as the concatenation 0x00000001 || salt || commitments.
    function automatic logic [31:0] msg_word(input int a);
        if (a == 0) return 32'h0000_0001;
        if (a <= 8) return salt_ref[a-1];
        return commit_mem[a-9];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_salt(input int k, input logic [31:0] v);
        salt_we = 1'b1;
        salt_a  = 3'(k);
        salt_d  = v;
        tick();
        salt_we = 1'b0;
        salt_ref[k] = v;
    endtask

    task automatic hash_read(input int a, output logic [31:0] d,
                             output logic crd, output logic [9:0] caddr);
        hash_addr = 11'(a);
        hash_rd   = 1'b1;
        #1;
        crd   = commit_rd;
        caddr = commit_addr;
        tick();
        hash_rd = 1'b0;
        d = hash_din;
    endtask

    task automatic read_check(input int a);
        logic [31:0] d;
        logic        crd;
        logic [9:0]  caddr;
        hash_read(a, d, crd, caddr);
        $display("read  addr=%0d data=%h exp=%h", a, d, msg_word(a));
        check("msg_word", d, msg_word(a));
        check("commit_rd", 32'(crd), 32'(a > 8));
        if (a > 8) check("commit_addr", 32'(caddr), 32'(a - 9));
    endtask

    task automatic push_word(input logic [31:0] w);
        check("ready_before_word", 32'(ready), 32'd1);
        hash_dout  = w;
        hash_valid = 1'b1;
        tick();
        hash_valid = 1'b0;
    endtask

    task automatic begin_run;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hash_start_pulse", 32'(hash_start), 32'd1);
        tick();
        check("hash_start_low", 32'(hash_start), 32'd0);
        check("ready_in_run", 32'(ready), 32'd1);
    endtask

    // Deliver the digest, perform the force-done handshake, then read back h1.
    task automatic finish_run(input int ack_delay, input int max_gap, input int done_before);
        int f0;
        f0 = force_seen;
        for (int k = 0; k < 8; k++) begin
            int gap;
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("ready_in_gap", 32'(ready), 32'd1);
            end
            push_word(digest_ref[k]);
        end
        check("ready_after_last", 32'(ready), 32'd0);
        check("force_done_high", 32'(force_done), 32'd1);
        // A stray valid outside RUN must not be captured.
        hash_dout  = 32'hBAD0_BAD0;
        hash_valid = 1'b1;
        for (int i = 1; i < ack_delay; i++) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        hash_valid = 1'b0;
        check("done_after_ack", 32'(done), 32'd1);
        check("force_done_dropped", 32'(force_done), 32'd0);
        check("force_cycles", 32'(force_seen - f0), 32'(ack_delay));
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_count", 32'(done_seen - done_before), 32'd1);
        for (int k = 0; k < 8; k++) begin
            h1_rd   = 1'b1;
            h1_addr = 3'(k);
            tick();
            $display("h1    word=%0d data=%h exp=%h", k, h1, digest_ref[k]);
            check("h1_word", h1, digest_ref[k]);
        end
        h1_rd = 1'b0;
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; salt_d = '0; salt_a = '0; salt_we = 1'b0;
        h1_rd = 1'b0; h1_addr = '0; hash_addr = '0; hash_rd = 1'b0;
        hash_dout = '0; hash_valid = 1'b0; ack = 1'b0;

        for (int k = 0; k < 1024; k++) commit_mem[k] = 32'(k);
        amap[0] = '{addr: 0,    data: 32'h1,   crd: 1'b0, caddr: 10'd0};
        amap[1] = '{addr: 1,    data: 32'h0,   crd: 1'b0, caddr: 10'd0};
        amap[2] = '{addr: 8,    data: 32'h7,   crd: 1'b0, caddr: 10'd0};
        amap[3] = '{addr: 9,    data: 32'h0,   crd: 1'b1, caddr: 10'd0};
        amap[4] = '{addr: 10,   data: 32'h1,   crd: 1'b1, caddr: 10'd1};
        amap[5] = '{addr: 1032, data: 32'h3FF, crd: 1'b1, caddr: 10'd1023};

        tick(); tick();
        rst_n = 1'b1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_hash_start", 32'(hash_start), 32'd0);
        check("rst_force_done", 32'(force_done), 32'd0);
        check("rst_hash_din", hash_din, 32'd0);
        check("rst_h1", h1, 32'd0);
        check("rst_commit_rd", 32'(commit_rd), 32'd0);
        check("input_length", in_len, 32'd33056);
        check("output_length", out_len, 32'd256);

        // Address map and full run with a 5-cycle ack delay.
        for (int k = 0; k < 8; k++) write_salt(k, 32'(k));
        for (int k = 0; k < 8; k++) digest_ref[k] = 32'hA0 + 32'(k);
        d0 = done_seen;
        begin_run();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] d;
            logic        crd;
            logic [9:0]  caddr;
            hash_read(amap[i].addr, d, crd, caddr);
            $display("amap  addr=%0d data=%h crd=%0d caddr=%0d", amap[i].addr, d, crd, caddr);
            check("amap_data", d, amap[i].data);
            check("amap_commit_rd", 32'(crd), 32'(amap[i].crd));
            check("amap_commit_addr", 32'(caddr), 32'(amap[i].caddr));
        end
        finish_run(5, 0, d0);

        // Ignored start and salt write during RUN, digest with gaps.
        for (int k = 0; k < 8; k++) digest_ref[k] = $urandom;
        d0 = done_seen;
        begin_run();
        start = 1'b1; salt_we = 1'b1; salt_a = 3'd0; salt_d = ~salt_ref[0];
        tick();
        start = 1'b0; salt_we = 1'b0;
        check("no_restart", 32'(hash_start), 32'd0);
        read_check(1);
        finish_run(2, 3, d0);

        // Reset in the middle of a run, then a clean restart.
        begin_run();
        read_check(9);
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        rst_n = 1'b0;
        tick();
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_force_done", 32'(force_done), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_hash_start", 32'(hash_start), 32'd0);
        check("midrst_hash_din", hash_din, 32'd0);
        check("midrst_h1", h1, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", 32'(ready), 32'd0);
        for (int k = 0; k < 8; k++) digest_ref[k] = $urandom;
        d0 = done_seen;
        begin_run();
        read_check(0);
        finish_run(1, 2, d0);

        // Randomised runs against the message/digest model.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) write_salt(k, $urandom);
            for (int k = 0; k < 1024; k++) commit_mem[k] = $urandom;
            for (int k = 0; k < 8; k++) digest_ref[k] = $urandom;
            d0 = done_seen;
            begin_run();
            for (int i = 0; i < 10; i++) read_check($urandom_range(0, 1032));
            read_check($urandom_range(1, 8));
            finish_run($urandom_range(1, 6), 3, d0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
